// File: rtl/solution_collector.sv
// Collects eight one-hot queen rows into a packed 24-bit solution word and buffers
// complete solutions in a show-ahead FIFO with a valid/ready output port.
module solution_collector #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 row_valid,
    input  logic [7:0]           row_data,
    input  logic                 abort,
    input  logic                 clear_flags,
    output logic                 full,
    output logic                 sol_valid,
    input  logic                 sol_ready,
    output logic [23:0]          sol_data,
    output logic [CNT_WIDTH-1:0] solution_count,
    output logic                 bad_row,
    output logic                 overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = DEPTH[AW:0];
    localparam logic [AW:0] CntOne  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StCollect, StDiscard} state_e;

    state_e               state_q, state_d;
    logic [2:0]           row_cnt_q, row_cnt_d;
    logic [20:0]          asm_q, asm_d;       // columns of rows 0..6
    logic [23:0]          mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic [CNT_WIDTH-1:0] sol_cnt_q;
    logic                 bad_row_q, overflow_q;

    logic       row_onehot, accept, last_row, bad_set;
    logic       push_req, push, pop, drop, fifo_full;
    logic [2:0] row_col;
    logic [23:0] sol_word;

    always_comb begin
        row_col = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (row_data[i]) row_col = 3'(i);
        end
    end

    assign row_onehot = (row_data != 8'd0) && ((row_data & (row_data - 8'd1)) == 8'd0);
    assign accept     = row_valid & ~abort;
    assign last_row   = (row_cnt_q == 3'd7);
    assign bad_set    = accept & ~row_onehot;
    assign push_req   = accept & last_row & row_onehot & (state_q == StCollect);
    assign fifo_full  = (count_q == FullCnt);
    assign pop        = sol_valid & sol_ready;
    // A simultaneous pop frees the slot the completing solution needs.
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & ~push;
    assign sol_word   = {row_col, asm_q};

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        asm_d     = asm_q;
        if (abort) begin
            state_d   = StIdle;
            row_cnt_d = 3'd0;
        end else if (row_valid) begin
            row_cnt_d = row_cnt_q + 3'd1;
            if (row_onehot) begin
                for (int r = 0; r < 7; r++) begin
                    if (row_cnt_q == 3'(r)) asm_d[3*r +: 3] = row_col;
                end
            end
            if (last_row) begin
                state_d = StIdle;
            end else if (!row_onehot) begin
                state_d = StDiscard;
            end else if (state_q == StIdle) begin
                state_d = StCollect;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            row_cnt_q  <= 3'd0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sol_cnt_q  <= '0;
            bad_row_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            asm_q      <= asm_d;
            count_q    <= count_d;
            bad_row_q  <= bad_set | (bad_row_q & ~clear_flags);
            overflow_q <= drop | (overflow_q & ~clear_flags);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && (sol_cnt_q != {CNT_WIDTH{1'b1}})) begin
                sol_cnt_q <= sol_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sol_word;
    end

    assign sol_valid      = (count_q != '0);
    assign sol_data       = sol_valid ? mem_q[rd_ptr_q] : 24'd0;
    assign full           = fifo_full;
    assign solution_count = sol_cnt_q;
    assign bad_row        = bad_row_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_solution_collector.sv
// Scoreboard bench for solution_collector: directed row sequences, expected words queued
// at issue time and popped by an output monitor.
module tb_solution_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        row_valid;
    logic [7:0]  row_data;
    logic        abort;
    logic        clear_flags;
    logic        full;
    logic        sol_valid;
    logic        sol_ready;
    logic [23:0] sol_data;
    logic [6:0]  solution_count;
    logic        bad_row;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb[$];

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [23:0] prev_data  = 24'd0;

    // Row r is byte r; expected words are packed by hand.
    localparam logic [63:0] R1 = 64'h0802_4004_2080_1001;  // 0x672BE0
    localparam logic [63:0] R2 = 64'h0102_0408_1020_4080;  // 0x053977
    localparam logic [63:0] R3 = 64'h0202_0202_0202_0202;  // 0x249249
    localparam logic [63:0] R4 = 64'h8040_2010_0804_0201;  // 0xFAC688
    localparam logic [63:0] R5 = 64'h0808_0808_0808_0808;  // 0x6DB6DB
    localparam logic [63:0] RB = 64'h0802_4004_2480_1001;  // row 3 = 0x24
    localparam logic [23:0] W1 = 24'h672BE0;
    localparam logic [23:0] W2 = 24'h053977;
    localparam logic [23:0] W3 = 24'h249249;
    localparam logic [23:0] W4 = 24'hFAC688;
    localparam logic [23:0] W5 = 24'h6DB6DB;

    solution_collector #(
        .DEPTH     (4),
        .CNT_WIDTH (7)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .row_valid      (row_valid),
        .row_data       (row_data),
        .abort          (abort),
        .clear_flags    (clear_flags),
        .full           (full),
        .sol_valid      (sol_valid),
        .sol_ready      (sol_ready),
        .sol_data       (sol_data),
        .solution_count (solution_count),
        .bad_row        (bad_row),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sol(input logic [63:0] rows, input logic [23:0] word,
                            input bit exp_push, input bit ready_last);
        for (int r = 0; r < 8; r++) begin
            row_valid = 1'b1;
            row_data  = rows[8*r +: 8];
            if (r == 7 && ready_last) sol_ready = 1'b1;
            if (r == 7 && exp_push) sb.push_back(word);
            tick();
        end
        row_valid = 1'b0;
        row_data  = 8'd0;
        if (ready_last) sol_ready = 1'b0;
    endtask

    // Output monitor: ordering against the scoreboard and head stability under stall.
    always @(negedge clk) begin
        if (reset && sol_valid && prev_valid && !prev_ready) begin
            check("head_hold", sol_data, prev_data);
        end
        if (reset && sol_valid && sol_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", sol_data, 32'hDEAD);
            end else begin
                check("sol_order", sol_data, sb.pop_front());
            end
        end
        prev_valid = sol_valid && reset;
        prev_ready = sol_ready;
        prev_data  = sol_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; row_valid = 1'b0; row_data = 8'd0;
        abort = 1'b0; clear_flags = 1'b0; sol_ready = 1'b0;
        tick(); tick();
        check("rst_valid", sol_valid, 0);
        check("rst_data", sol_data, 0);
        check("rst_full", full, 0);
        check("rst_count", solution_count, 0);
        check("rst_bad", bad_row, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;
        tick();

        // Single solution with consumer ready.
        sol_ready = 1'b1;
        send_sol(R1, W1, 1'b1, 1'b0);
        check("t1_valid", sol_valid, 1);
        check("t1_data", sol_data, W1);
        check("t1_count", solution_count, 1);
        tick();
        check("t1_valid_after", sol_valid, 0);

        // Bad row discards, next clean sequence pushes, then clear.
        send_sol(RB, 24'd0, 1'b0, 1'b0);
        check("t2_bad", bad_row, 1);
        check("t2_nopush", sol_valid, 0);
        check("t2_count", solution_count, 1);
        send_sol(R2, W2, 1'b1, 1'b0);
        check("t2_count2", solution_count, 2);
        check("t2_data", sol_data, W2);
        tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("t2_clear", bad_row, 0);

        // Abort after 5 rows, with a bad row_valid in the same cycle.
        for (int r = 0; r < 5; r++) begin
            row_valid = 1'b1;
            row_data  = R4[8*r +: 8];
            tick();
        end
        abort = 1'b1; row_data = 8'h00;
        tick();
        abort = 1'b0; row_valid = 1'b0;
        check("t3_abort_bad", bad_row, 0);
        check("t3_abort_nopush", sol_valid, 0);
        send_sol(R3, W3, 1'b1, 1'b0);
        check("t3_valid", sol_valid, 1);
        check("t3_data", sol_data, W3);
        check("t3_count", solution_count, 3);
        tick();

        // Fill, overflow, then completion with a simultaneous pop.
        sol_ready = 1'b0;
        send_sol(R1, W1, 1'b1, 1'b0);
        send_sol(R2, W2, 1'b1, 1'b0);
        send_sol(R3, W3, 1'b1, 1'b0);
        check("t4_notfull", full, 0);
        send_sol(R4, W4, 1'b1, 1'b0);
        check("t4_full", full, 1);
        check("t4_count", solution_count, 7);
        send_sol(R5, W5, 1'b0, 1'b0);
        check("t4_ovf", overflow, 1);
        check("t4_count_ovf", solution_count, 7);
        check("t4_head", sol_data, W1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("t4_ovf_clear", overflow, 0);
        send_sol(R5, W5, 1'b1, 1'b1);
        check("t4_ovf_pop", overflow, 0);
        check("t4_count_pop", solution_count, 8);
        check("t4_full_pop", full, 1);
        check("t4_head_pop", sol_data, W2);
        sol_ready = 1'b1;
        repeat (4) tick();
        sol_ready = 1'b0;
        check("t4_drained", sol_valid, 0);

        // Back-pressure ordering.
        send_sol(R2, W2, 1'b1, 1'b0);
        send_sol(R4, W4, 1'b1, 1'b0);
        send_sol(R5, W5, 1'b1, 1'b0);
        check("t5_count", solution_count, 11);
        sol_ready = 1'b1; tick();
        sol_ready = 1'b0; tick();
        sol_ready = 1'b1; tick();
        sol_ready = 1'b0; tick();
        sol_ready = 1'b1; tick();
        sol_ready = 1'b0;
        check("t5_empty", sol_valid, 0);

        // Reset with two entries held and a partial assembly.
        send_sol(R1, W1, 1'b1, 1'b0);
        send_sol(R3, W3, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            row_valid = 1'b1;
            row_data  = R2[8*r +: 8];
            tick();
        end
        row_valid = 1'b0;
        reset = 1'b0;
        sb.delete();
        tick();
        check("t6_valid", sol_valid, 0);
        check("t6_data", sol_data, 0);
        check("t6_full", full, 0);
        check("t6_count", solution_count, 0);
        check("t6_flags", {bad_row, overflow}, 0);
        reset = 1'b1;
        send_sol(R4, W4, 1'b1, 1'b0);
        check("t6_valid2", sol_valid, 1);
        check("t6_count2", solution_count, 1);
        check("t6_data2", sol_data, W4);
        sol_ready = 1'b1;
        tick();
        sol_ready = 1'b0;
        check("t6_empty", sol_valid, 0);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/solution_collector.md
Name: solution_collector

Overview:
- Sits directly downstream of the 8-queen datapath and consumes its `out_bus`.
- The controller drives the datapath's enable_output once per row (row 0 up to row 7), and each strobe presents that row's one-hot queen byte here.
- This block converts each byte to a 3-bit column, assembles the eight columns into one packed solution word, and buffers complete solutions in a FIFO with a valid/ready output port.
- It also flags malformed rows, counts solutions and back-pressures the controller when the FIFO is full.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- CNT_WIDTH, 7, width of the saturating solution counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- row_valid  in  1  one row byte is presented this cycle (tied to the datapath enable_output).
- row_data  in  8  one-hot queen position of the current row, from the datapath out_bus; bit k set means column k.
- abort  in  1  the controller backtracked; discard the partial assembly.
- clear_flags  in  1  clears the sticky flags bad_row and overflow.
- full  out  1  FIFO holds DEPTH entries; the controller must not finish a new solution.
- sol_valid  out  1  the FIFO head is valid.
- sol_ready  in  1  the consumer accepts the head.
- sol_data  out  24  FIFO head; the column of row r is in bits [3r+2:3r].
- solution_count  out  CNT_WIDTH  number of solutions pushed since reset.
- bad_row  out  1  sticky; a row byte was not one-hot.
- overflow  out  1  sticky; a completed solution was dropped.

Behaviour:
- Reset (reset=0 at an edge):
  - row counter 0, state IDLE, FIFO empty.
  - sol_valid=0, sol_data=0, full=0, solution_count=0, bad_row=0, overflow=0.
  - Reset wins over every other input.
- States:
  - IDLE (row_cnt=0).
  - COLLECT (1 to 7 rows captured, all valid).
  - DISCARD (partial assembly contains a bad row).
- Row acceptance on each edge with row_valid=1 and abort=0:
  - Column = index of the single set bit.
  - Zero bits set or more than one bit set means a bad row: set bad_row and go to (or stay in) DISCARD.
  - Otherwise write the column into assembly slot row_cnt.
  - row_cnt increments, wrapping 7 to 0.
- Transitions:
  - IDLE goes to COLLECT on a good row, or to DISCARD on a bad row.
  - COLLECT goes to DISCARD on a bad row.
  - On the 8th row (row_cnt=7): COLLECT completes a solution if that row is good; DISCARD drops the solution silently. Either way the next state is IDLE.
- Completion:
  - The assembled word, including the 8th column, is pushed at the same edge that samples row 7.
  - sol_valid is high in the following cycle if the FIFO was empty. Latency is 1 cycle.
  - solution_count increments on each push and saturates at 2^CNT_WIDTH-1.
- Full FIFO at completion:
  - If sol_valid&sol_ready is true in the same cycle, the pop frees a slot and the push is accepted.
  - Otherwise the solution is dropped, overflow is set and solution_count is unchanged.
- abort:
  - row_cnt returns to 0 and the state to IDLE.
  - A row_valid in the same cycle is ignored and cannot set bad_row.
  - FIFO contents are unaffected.
- Output port: show-ahead FIFO.
  - sol_data is stable while sol_valid=1 and sol_ready=0.
  - A pop occurs on an edge with sol_valid&sol_ready.
  - sol_ready while empty has no effect.
- full is registered from the occupancy count: full=1 exactly when occupancy equals DEPTH.
- clear_flags: if a set event occurs in the same cycle, the set wins.
- Pointers are log2(DEPTH) bits and wrap naturally; occupancy is log2(DEPTH)+1 bits.

Test Plan:
- Single solution, sol_ready=1: rows 01,10,80,20,04,40,02,08 on consecutive cycles.
  - Required: sol_valid=1 one cycle after the 8th row, sol_data=0x672BE0, solution_count=1.
  - Required: sol_valid=0 on the next cycle.
- Bad row: a valid solution sequence but row 3 = 0x24.
  - Required: bad_row=1, no push, solution_count unchanged.
  - The next clean 8-row sequence is pushed normally.
  - Then clear_flags gives bad_row=0.
- Abort mid-assembly: 5 rows, then abort asserted together with row_valid.
  - Required: row_cnt=0.
  - A following full 8-row sequence produces exactly one solution with the correct packing.
- Fill and overflow, sol_ready=0, DEPTH=4: push 4 solutions.
  - Required: full=1 after the 4th.
  - A 5th solution gives overflow=1, solution_count=4, and the head still holds solution 1.
  - Repeat with sol_ready=1 during the 5th completion: the push is accepted and overflow stays 0.
- Back-pressure order: push 3 distinct solutions, then toggle sol_ready 1,0,1,0,1.
  - Required: outputs appear in push order, and sol_data is held while sol_ready=0.
- Reset mid-operation: reset=0 after 3 rows with 2 FIFO entries held.
  - Required: all outputs 0 and the FIFO empty.
  - The next 8 good rows produce sol_valid with solution_count=1.
